// File: rtl/spm_dma_arbiter.sv
// Shares SPM port B between the MEM stage (always wins) and a word-copy DMA
// that steals idle port cycles: RD -> CAP -> WR per word, 3 cycles when uncontended.
module spm_dma_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] mem_spm_addr,
  input  logic              mem_spm_as_,
  input  logic              mem_spm_rw,
  input  logic [DATA_W-1:0] mem_spm_wr_data,
  output logic [DATA_W-1:0] mem_spm_rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  input  logic              dma_start,
  input  logic              dma_abort,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [ADDR_W:0]   dma_len,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W:0]   dma_remain
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic                done_q, done_d;

  logic                dma_req;
  logic                dma_rw;
  logic [ADDR_W-1:0]   dma_addr;
  logic                grant;

  // The DMA owns the port only in cycles where the MEM strobe is inactive.
  assign grant = mem_spm_as_;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    remain_d = remain_q;
    buf_d    = buf_q;
    done_d   = 1'b0;
    dma_req  = 1'b0;
    dma_rw   = 1'b1;
    dma_addr = src_q;

    case (state_q)
      S_IDLE: begin
        if (dma_start && !dma_abort) begin
          if (dma_len != '0) begin
            src_d    = dma_src;
            dst_d    = dma_dst;
            remain_d = dma_len;
            state_d  = S_RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RD: begin
        dma_req  = 1'b1;
        dma_addr = src_q;
        if (grant) begin
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        // Read data always belongs to the RD cycle, even if MEM holds the port now.
        buf_d   = spm_rd_data;
        state_d = S_WR;
      end
      S_WR: begin
        dma_req  = 1'b1;
        dma_rw   = 1'b0;
        dma_addr = dst_q;
        if (grant) begin
          src_d    = src_q + ADDR_W'(1);
          dst_d    = dst_q + ADDR_W'(1);
          remain_d = remain_q - (ADDR_W+1)'(1);
          if (remain_q == (ADDR_W+1)'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (dma_abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      remain_d = '0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      buf_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      remain_q <= remain_d;
      buf_q    <= buf_d;
      done_q   <= done_d;
    end
  end

  // Reset forces the port idle immediately, even against an active MEM strobe.
  always_comb begin
    spm_as_     = 1'b1;
    spm_rw      = 1'b1;
    spm_addr    = '0;
    spm_wr_data = '0;
    if (reset_) begin
      if (!mem_spm_as_) begin
        spm_as_     = 1'b0;
        spm_rw      = mem_spm_rw;
        spm_addr    = mem_spm_addr;
        spm_wr_data = mem_spm_wr_data;
      end else if (dma_req) begin
        spm_as_     = 1'b0;
        spm_rw      = dma_rw;
        spm_addr    = dma_addr;
        spm_wr_data = dma_rw ? '0 : buf_q;
      end
    end
  end

  assign mem_spm_rd_data = spm_rd_data;
  assign dma_busy        = (state_q != S_IDLE);
  assign dma_done        = done_q;
  assign dma_remain      = remain_q;

endmodule

// File: tb/tb_spm_dma_arbiter.sv
// Scoreboard bench for spm_dma_arbiter with a behavioural SPM behind port B.
module tb_spm_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset_;
  logic [11:0] mem_spm_addr;
  logic        mem_spm_as_;
  logic        mem_spm_rw;
  logic [31:0] mem_spm_wr_data;
  logic [31:0] mem_spm_rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data;
  logic        dma_start;
  logic        dma_abort;
  logic [11:0] dma_src;
  logic [11:0] dma_dst;
  logic [12:0] dma_len;
  logic        dma_busy;
  logic        dma_done;
  logic [12:0] dma_remain;

  spm_dma_arbiter dut (
    .clk(clk), .reset_(reset_),
    .mem_spm_addr(mem_spm_addr), .mem_spm_as_(mem_spm_as_), .mem_spm_rw(mem_spm_rw),
    .mem_spm_wr_data(mem_spm_wr_data), .mem_spm_rd_data(mem_spm_rd_data),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .dma_start(dma_start), .dma_abort(dma_abort), .dma_src(dma_src), .dma_dst(dma_dst),
    .dma_len(dma_len), .dma_busy(dma_busy), .dma_done(dma_done), .dma_remain(dma_remain)
  );

  always #5 clk = ~clk;

  typedef struct {logic rw; logic [11:0] addr; logic [31:0] wd;} acc_t;
  typedef struct {int cyc; logic busy; logic [12:0] remain; logic done; bit chk_port;} st_t;
  typedef struct {logic [11:0] addr; logic [31:0] exp;} mc_t;

  acc_t        accq[$];
  logic [31:0] rdq[$];
  int          doneq[$];
  st_t         stq[$];
  mc_t         memq[$];

  int    cyc = 0;
  bit    fin = 1'b0;
  bit    prev_rd = 1'b0;
  int    checks = 0;
  int    failures = 0;
  string tname = "reset";

  // Behavioural SPM: unwritten words read back as a per-address pattern.
  logic [31:0] mem [4096];
  bit          wrf [4096];
  logic [31:0] rd_q;

  function automatic logic [31:0] pat(input logic [11:0] a);
    return {16'hC0DE, 4'h0, a};
  endfunction

  function automatic logic [31:0] mrd(input logic [11:0] a);
    return wrf[a] ? mem[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!spm_as_) begin
      if (!spm_rw) begin
        mem[spm_addr] <= spm_wr_data;
        wrf[spm_addr] <= 1'b1;
      end else begin
        rd_q <= mrd(spm_addr);
      end
    end
  end
  assign spm_rd_data = rd_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL [%s] %s: got %0h expected %0h (cycle %0d)", tname, nm, act, exp, cyc);
    end
  endtask

  task automatic err(input string nm);
    checks++;
    failures++;
    $display("FAIL [%s] %s (cycle %0d)", tname, nm, cyc);
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  // Monitor: every comparison happens here, on the falling edge.
  initial begin
    acc_t a;
    st_t  s;
    forever begin
      @(negedge clk);
      if (prev_rd) begin
        if (rdq.size() == 0) err("mem_rd_unexpected");
        else chk("mem_rd_data", mem_spm_rd_data, rdq.pop_front());
      end
      prev_rd = reset_ && !mem_spm_as_ && mem_spm_rw;
      if (!spm_as_) begin
        if (accq.size() == 0) begin
          err("port_unexpected_access");
        end else begin
          a = accq.pop_front();
          chk("port_rw", spm_rw, a.rw);
          chk("port_addr", spm_addr, a.addr);
          if (!a.rw) chk("port_wdata", spm_wr_data, a.wd);
        end
      end
      if (dma_done) begin
        if (doneq.size() == 0) err("done_unexpected");
        else chk("done_cycle", cyc, doneq.pop_front());
      end
      while (stq.size() > 0 && stq[0].cyc <= cyc) begin
        s = stq.pop_front();
        if (s.cyc < cyc) begin
          err("status_missed");
        end else begin
          chk("busy", dma_busy, s.busy);
          chk("remain", dma_remain, s.remain);
          chk("done", dma_done, s.done);
          if (s.chk_port)
            chk("idle_port", {spm_as_, spm_rw, spm_addr, spm_wr_data}, {1'b1, 1'b1, 12'h0, 32'h0});
        end
      end
      if (fin) begin
        chk("acc_queue_drained", accq.size(), 0);
        chk("done_queue_drained", doneq.size(), 0);
        chk("rd_queue_drained", rdq.size(), 0);
        foreach (memq[i]) chk("spm_contents", mrd(memq[i].addr), memq[i].exp);
        summary();
        $finish;
      end
      if (cyc > 3000) begin
        err("timeout");
        summary();
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input logic rw, input logic [11:0] addr, input logic [31:0] wd);
    accq.push_back('{rw: rw, addr: addr, wd: wd});
  endtask

  task automatic push_st(input int c, input logic busy, input logic [12:0] rem,
                         input logic done, input bit port);
    stq.push_back('{cyc: c, busy: busy, remain: rem, done: done, chk_port: port});
  endtask

  // Uncontended copy: alternating read/write per word, destination expectations recorded.
  task automatic push_copy(input logic [11:0] src, input logic [11:0] dst, input int n);
    for (int k = 0; k < n; k++) begin
      push_acc(1'b1, src + 12'(k), 32'h0);
      push_acc(1'b0, dst + 12'(k), pat(src + 12'(k)));
      memq.push_back('{addr: dst + 12'(k), exp: pat(src + 12'(k))});
    end
  endtask

  task automatic launch(input logic [11:0] src, input logic [11:0] dst, input logic [12:0] len);
    dma_start = 1'b1;
    dma_src   = src;
    dma_dst   = dst;
    dma_len   = len;
  endtask

  initial begin
    int s;
    reset_ = 1'b0;
    mem_spm_addr = '0; mem_spm_as_ = 1'b1; mem_spm_rw = 1'b1; mem_spm_wr_data = '0;
    dma_start = 1'b0; dma_abort = 1'b0; dma_src = '0; dma_dst = '0; dma_len = '0;
    push_st(1, 1'b0, 13'd0, 1'b0, 1'b1);
    push_st(2, 1'b0, 13'd0, 1'b0, 1'b1);
    tick(); tick(); tick();
    reset_ = 1'b1;
    tick();

    // Uncontended 4-word copy.
    tname = "copy4";
    s = cyc;
    launch(12'h010, 12'h100, 13'd4);
    push_copy(12'h010, 12'h100, 4);
    doneq.push_back(s + 13);
    push_st(s + 1, 1'b1, 13'd4, 1'b0, 1'b0);
    push_st(s + 13, 1'b0, 13'd0, 1'b1, 1'b0);
    tick(); dma_start = 1'b0;
    repeat (15) tick();

    // MEM holds the port for 5 cycles starting at the first RD cycle.
    tname = "preempt_rd";
    s = cyc;
    launch(12'h200, 12'h280, 13'd2);
    doneq.push_back(s + 12);
    push_st(s + 5, 1'b1, 13'd2, 1'b0, 1'b0);
    push_st(s + 12, 1'b0, 13'd0, 1'b1, 1'b0);
    tick(); dma_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_spm_as_ = 1'b0; mem_spm_rw = 1'b1; mem_spm_addr = 12'h300 + 12'(i);
      mem_spm_wr_data = 32'h0;
      push_acc(1'b1, 12'h300 + 12'(i), 32'h0);
      rdq.push_back(pat(12'h300 + 12'(i)));
      tick();
    end
    mem_spm_as_ = 1'b1;
    push_copy(12'h200, 12'h280, 2);
    repeat (10) tick();

    // MEM read during CAP, MEM write during WR.
    tname = "preempt_cap_wr";
    s = cyc;
    launch(12'h040, 12'h0C0, 13'd1);
    push_acc(1'b1, 12'h040, 32'h0);
    doneq.push_back(s + 5);
    push_st(s + 3, 1'b1, 13'd1, 1'b0, 1'b0);
    tick(); dma_start = 1'b0;
    tick();
    mem_spm_as_ = 1'b0; mem_spm_rw = 1'b1; mem_spm_addr = 12'h020;
    push_acc(1'b1, 12'h020, 32'h0);
    rdq.push_back(pat(12'h020));
    tick();
    mem_spm_rw = 1'b0; mem_spm_addr = 12'h060; mem_spm_wr_data = 32'h1234_5678;
    push_acc(1'b0, 12'h060, 32'h1234_5678);
    memq.push_back('{addr: 12'h060, exp: 32'h1234_5678});
    tick();
    mem_spm_as_ = 1'b1; mem_spm_rw = 1'b1; mem_spm_wr_data = 32'h0;
    push_acc(1'b0, 12'h0C0, pat(12'h040));
    memq.push_back('{addr: 12'h0C0, exp: pat(12'h040)});
    repeat (4) tick();

    // Pointer wrap-around and remain stepping.
    tname = "wrap";
    s = cyc;
    launch(12'hFFE, 12'h7FE, 13'd4);
    for (int k = 0; k < 4; k++) begin
      push_acc(1'b1, 12'hFFE + 12'(k), 32'h0);
      push_acc(1'b0, 12'h7FE + 12'(k), pat(12'hFFE + 12'(k)));
      memq.push_back('{addr: 12'h7FE + 12'(k), exp: pat(12'hFFE + 12'(k))});
    end
    doneq.push_back(s + 13);
    push_st(s + 1, 1'b1, 13'd4, 1'b0, 1'b0);
    push_st(s + 3, 1'b1, 13'd4, 1'b0, 1'b0);
    push_st(s + 4, 1'b1, 13'd3, 1'b0, 1'b0);
    push_st(s + 7, 1'b1, 13'd2, 1'b0, 1'b0);
    push_st(s + 10, 1'b1, 13'd1, 1'b0, 1'b0);
    push_st(s + 13, 1'b0, 13'd0, 1'b1, 1'b0);
    tick(); dma_start = 1'b0;
    repeat (15) tick();

    // Zero-length start: done next cycle, no port access.
    tname = "len0";
    s = cyc;
    launch(12'h400, 12'h500, 13'd0);
    doneq.push_back(s + 1);
    push_st(s + 1, 1'b0, 13'd0, 1'b1, 1'b0);
    tick(); dma_start = 1'b0;
    repeat (3) tick();

    // A second start mid-copy is ignored.
    tname = "start_busy";
    s = cyc;
    launch(12'h050, 12'h150, 13'd3);
    push_copy(12'h050, 12'h150, 3);
    memq.push_back('{addr: 12'h160, exp: pat(12'h160)});
    doneq.push_back(s + 10);
    push_st(s + 5, 1'b1, 13'd2, 1'b0, 1'b0);
    push_st(s + 10, 1'b0, 13'd0, 1'b1, 1'b0);
    tick(); dma_start = 1'b0;
    repeat (3) tick();
    launch(12'h060, 12'h160, 13'd2);
    tick(); dma_start = 1'b0;
    repeat (10) tick();

    // Abort in the WR cycle of the first word: that write lands, nothing after.
    tname = "abort";
    s = cyc;
    launch(12'h070, 12'h170, 13'd4);
    push_acc(1'b1, 12'h070, 32'h0);
    push_acc(1'b0, 12'h170, pat(12'h070));
    memq.push_back('{addr: 12'h170, exp: pat(12'h070)});
    memq.push_back('{addr: 12'h171, exp: pat(12'h171)});
    push_st(s + 3, 1'b1, 13'd4, 1'b0, 1'b0);
    push_st(s + 4, 1'b0, 13'd0, 1'b0, 1'b0);
    tick(); dma_start = 1'b0;
    tick(); tick();
    dma_abort = 1'b1;
    tick(); dma_abort = 1'b0;
    repeat (4) tick();

    // Abort and start together in IDLE: abort wins, no copy.
    tname = "abort_start";
    s = cyc;
    launch(12'h090, 12'h190, 13'd2);
    dma_abort = 1'b1;
    memq.push_back('{addr: 12'h190, exp: pat(12'h190)});
    push_st(s + 1, 1'b0, 13'd0, 1'b0, 1'b0);
    tick(); dma_start = 1'b0; dma_abort = 1'b0;
    repeat (8) tick();

    // Asynchronous reset during WR.
    tname = "reset_mid";
    s = cyc;
    launch(12'h080, 12'h180, 13'd2);
    push_acc(1'b1, 12'h080, 32'h0);
    memq.push_back('{addr: 12'h180, exp: pat(12'h180)});
    push_st(s + 3, 1'b0, 13'd0, 1'b0, 1'b1);
    push_st(s + 8, 1'b0, 13'd0, 1'b0, 1'b1);
    tick(); dma_start = 1'b0;
    tick(); tick();
    reset_ = 1'b0;
    tick(); tick();
    reset_ = 1'b1;
    repeat (8) tick();

    fin = 1'b1;
  end

endmodule

// File: doc/spm_dma_arbiter.md
Name: spm_dma_arbiter

Overview:
- Owns scratchpad memory port B and shares it between the CPU MEM stage and an internal word-copy DMA engine.
- The MEM stage always has priority. The DMA engine only uses idle port-B cycles to copy a block of words from one SPM region to another.
- Sits between the MEM stage and the SPM port-B pins, transparently to the MEM stage.
- Software configures and launches copies via the dma_* sideband.

Parameters:
ADDR_W, 12, SPM word-address width (matches SpmAddrBus)
DATA_W, 32, word width (matches WordDataBus)

Ports:
clk  in  1  clock
reset_  in  1  asynchronous reset, active low
mem_spm_addr  in  ADDR_W  MEM-stage address
mem_spm_as_  in  1  MEM-stage address strobe, active low
mem_spm_rw  in  1  MEM-stage read(1)/write(0)
mem_spm_wr_data  in  DATA_W  MEM-stage write data
mem_spm_rd_data  out  DATA_W  MEM-stage read data
spm_addr  out  ADDR_W  SPM port-B address
spm_as_  out  1  SPM port-B strobe, active low
spm_rw  out  1  SPM port-B read/write
spm_wr_data  out  DATA_W  SPM port-B write data
spm_rd_data  in  DATA_W  SPM port-B read data (1-cycle synchronous latency)
dma_start  in  1  launch pulse
dma_abort  in  1  abort pulse
dma_src  in  ADDR_W  source word address
dma_dst  in  ADDR_W  destination word address
dma_len  in  ADDR_W+1  word count, 0..2^ADDR_W
dma_busy  out  1  copy in progress
dma_done  out  1  one-cycle pulse on normal completion
dma_remain  out  ADDR_W+1  words still to write

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_=0, any time including mid-copy):
  - FSM goes to IDLE; all pointers, counters and the data buffer clear.
  - dma_busy=0, dma_done=0, dma_remain=0.
  - Port B is driven idle: spm_as_=1 (disabled), spm_rw=1 (READ), spm_addr=0, spm_wr_data=0.
- Port mux (combinational):
  - If mem_spm_as_=0, all four MEM signals pass to port B unchanged and the DMA is not granted that cycle.
  - Otherwise port B is driven by the DMA request, or idle if the DMA requests nothing.
- mem_spm_rd_data = spm_rd_data always. The MEM stage sees identical timing with or without the arbiter.
- FSM states: IDLE, RD, CAP, WR.
  - IDLE:
    - dma_start=1 and dma_len!=0: latch src, dst, len into registers; dma_remain=len; go to RD; dma_busy=1 from the next cycle.
    - dma_start=1 and dma_len=0: no port access; dma_done pulses the next cycle; busy stays 0.
  - RD:
    - Request a read of src_ptr.
    - If granted (mem_spm_as_=1): go to CAP.
    - If not granted: stay in RD and re-request next cycle.
  - CAP: capture spm_rd_data into the buffer unconditionally. The data reflects the previous-cycle read even if MEM owns the port this cycle. Go to WR.
  - WR:
    - Request a write of the buffer to dst_ptr.
    - If not granted: hold.
    - If granted:
      - src_ptr++ and dst_ptr++, both modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0).
      - dma_remain--.
      - If dma_remain reaches 0: go to IDLE with dma_done=1 for exactly one cycle.
      - Otherwise: go to RD.
- Throughput: 3 cycles per word when uncontended.
- Copy order is ascending. Overlapping regions produce exactly the result of a sequential ascending word copy.
- dma_start while busy: ignored; the latched parameters are unchanged.
- dma_abort while busy:
  - Return to IDLE at the next edge; busy=0, remain=0, no done pulse.
  - A write granted in the same cycle as the abort still completes; no further accesses follow.
- dma_abort in IDLE: no effect.
- dma_abort and dma_start in the same cycle: abort wins (start ignored).
- Simultaneous MEM and DMA access in the same cycle is impossible by construction. The DMA never writes while the MEM strobe is low.

Test Plan:
- Copy, no contention: SPM[0x010..0x013]=A0..A3, start src=0x010 dst=0x100 len=4, mem_spm_as_=1 -> 12 port cycles, done pulse at cycle 13, SPM[0x100..0x103]=A0..A3, busy low after done.
- MEM preemption in RD: copy len=2 with mem_spm_as_=0 for 5 cycles from the first RD cycle -> MEM accesses pass untouched with correct rd_data; DMA stalls 5 cycles; final contents correct; done delayed exactly 5 cycles.
- MEM preemption in CAP and WR: MEM read of 0x020 coincides with CAP, then a MEM write coincides with WR -> buffer holds the DMA source word; MEM gets SPM[0x020] next cycle; DMA write issues the cycle after MEM releases.
- Wrap-around: src=0xFFE dst=0x7FE len=4 -> reads 0xFFE,0xFFF,0x000,0x001; writes 0x7FE..0x801; dma_remain steps 4,3,2,1,0.
- len=0 and start-while-busy: start len=0 -> done pulse next cycle, no spm_as_ asserted. Start len=3, then a second start with different params mid-copy -> ignored; only the first copy is performed.
- Abort and reset: abort after 1 word of len=4 -> 1 word written, busy=0, no done. Second run: reset_ low mid-WR -> all outputs at reset values immediately (async); no write after reset release.
